wshb_arbiter: RTL

- Two-master, one-slave Wishbone classic arbiter, 16-bit data and 32-bit address, placed in front of the SDRAM controller's Wishbone slave.
- Master 0 is the VGA frame-buffer reader that refills the display FIFO. Master 1 is the frame writer (test-pattern or video-input loader).
- Grants are round-robin. Each grant is bounded by MAXBURST acknowledged transfers whenever the other master is waiting, so the display FIFO is never starved by a long write stream.

---
 rtl/wshb_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of a single slave.
// Grants are bounded to MAXBURST acked transfers whenever the other master waits.
module wshb_arbiter #(
   parameter int unsigned MAXBURST = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [31:0] m0_adr,
   input  logic [1:0]  m0_sel,
   input  logic [15:0] m0_dat_ms,
   output logic [15:0] m0_dat_sm,
   output logic        m0_ack,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [31:0] m1_adr,
   input  logic [1:0]  m1_sel,
   input  logic [15:0] m1_dat_ms,
   output logic [15:0] m1_dat_sm,
   output logic        m1_ack,
   output logic        s_cyc,
   output logic        s_stb,
   output logic        s_we,
   output logic [31:0] s_adr,
   output logic [1:0]  s_sel,
   output logic [15:0] s_dat_ms,
   input  logic [15:0] s_dat_sm,
   input  logic        s_ack,
   output logic [1:0]  grant
);

   localparam int unsigned CW = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST);
   localparam logic [CW-1:0] CNT_PRE = CW'(MAXBURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   state_t        state_r;
   state_t        state_nxt;
   logic          last_r;
   logic [CW-1:0] count_r;
   logic          own_cyc;
   logic          own_stb;
   logic          other_cyc;
   logic          xfer;
   logic          at_limit;

   assign grant     = state_r;
   assign m0_dat_sm = s_dat_sm;
   assign m1_dat_sm = s_dat_sm;

   // Bus mux: the registered owner drives the slave; IDLE drops any slave ack.
   always_comb begin
      s_cyc     = 1'b0;
      s_stb     = 1'b0;
      s_we      = 1'b0;
      s_adr     = 32'h0000_0000;
      s_sel     = 2'b00;
      s_dat_ms  = 16'h0000;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      own_cyc   = 1'b0;
      own_stb   = 1'b0;
      other_cyc = 1'b0;
      case (state_r)
         GNT0: begin
            s_cyc     = m0_cyc;
            s_stb     = m0_stb;
            s_we      = m0_we;
            s_adr     = m0_adr;
            s_sel     = m0_sel;
            s_dat_ms  = m0_dat_ms;
            m0_ack    = s_ack;
            own_cyc   = m0_cyc;
            own_stb   = m0_stb;
            other_cyc = m1_cyc;
         end
         GNT1: begin
            s_cyc     = m1_cyc;
            s_stb     = m1_stb;
            s_we      = m1_we;
            s_adr     = m1_adr;
            s_sel     = m1_sel;
            s_dat_ms  = m1_dat_ms;
            m1_ack    = s_ack;
            own_cyc   = m1_cyc;
            own_stb   = m1_stb;
            other_cyc = m0_cyc;
         end
         IDLE: begin
         end
         default: begin
         end
      endcase
   end

   assign xfer     = s_ack & own_stb;
   assign at_limit = (count_r == CNT_MAX) || ((count_r == CNT_PRE) && xfer);

   // Next-state: ties go to the master that did not own the bus last.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         IDLE: begin
            if (m0_cyc && !m1_cyc) begin
               state_nxt = GNT0;
            end else if (!m0_cyc && m1_cyc) begin
               state_nxt = GNT1;
            end else if (m0_cyc && m1_cyc) begin
               state_nxt = last_r ? GNT0 : GNT1;
            end else begin
               state_nxt = IDLE;
            end
         end
         GNT0, GNT1: begin
            if (!own_cyc || (other_cyc && at_limit)) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = state_r;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, last-owner and saturating burst counter registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= IDLE;
         last_r  <= 1'b1;
         count_r <= {CW{1'b0}};
      end else begin
         state_r <= state_nxt;
         if ((state_r == IDLE) && (state_nxt != IDLE)) begin
            count_r <= {CW{1'b0}};
            last_r  <= (state_nxt == GNT1);
         end else if ((state_r != IDLE) && xfer && (count_r != CNT_MAX)) begin
            count_r <= count_r + CW'(1);
         end
      end
   end

endmodule
